writeback_stage: RTL and testbench

Final stage of the pipelined RV32 core. It sits directly upstream of `register_file`, which has a single write port, and owns that port. Two sources write through it:
- the pipeline MEM/WB lane, which selects the result word and buffers writes in a 2-entry FIFO;
- the multi-cycle divider lane, which holds one write in a register.

It arbitrates the lanes round-robin, drives `we3`/`a3`/`wd3`, and publishes a pending-write mask for the hazard unit.

---
 rtl/writeback_stage_pkg.sv | 39 +++
 rtl/writeback_stage_wb_fifo.sv | 52 +++++
 rtl/writeback_stage.sv | 133 +++++++++++++
 tb/tb_writeback_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the writeback stage: result-source and
// grant encodings plus the buffered write entry layout.
package writeback_stage_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } resultsrc_e;

  typedef enum logic {
    GRANT_PIPE = 1'b0,
    GRANT_DIV  = 1'b1
  } grant_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // The reserved encoding falls back to the ALU word.
  function automatic logic [XLEN-1:0] select_result(
    input logic [1:0]      src,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] mem,
    input logic [XLEN-1:0] pc4
  );
    case (src)
      RES_MEM: return mem;
      RES_PC4: return pc4;
      default: return alu;
    endcase
  endfunction

endpackage

// File: rtl/writeback_stage_wb_fifo.sv
// Small synchronous FIFO for the pipeline lane; exposes every slot and its
// valid bit so the parent can build the pending-write mask.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            din,
  output logic [W-1:0]            head,
  output logic                    full,
  output logic                    empty,
  output logic [DEPTH-1:0]        entry_valid,
  output logic [DEPTH-1:0][W-1:0] entries
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           wr_ptr;
  logic [DEPTH-1:0][W-1:0] mem;
  logic [DEPTH-1:0]        vld;

  // Per-slot valid bits replace a counter; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      mem    <= '0;
      vld    <= '0;
    end else begin
      if (pop && !empty) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (push && !full) begin
        mem[wr_ptr] <= din;
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
    end
  end

  assign head        = mem[rd_ptr];
  assign full        = &vld;
  assign empty       = ~|vld;
  assign entry_valid = vld;
  assign entries     = mem;

endmodule

// File: rtl/writeback_stage.sv
// Register-file write-port owner: merges the MEM/WB FIFO lane and the divider
// holding register with round-robin arbitration and publishes pending writes.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_regwrite,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [1:0]            in_resultsrc,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_read_data,
  input  logic [XLEN-1:0]       in_pc_plus4,
  input  logic                  div_valid,
  output logic                  div_ready,
  input  logic [REG_ADDR_W-1:0] div_rd,
  input  logic [XLEN-1:0]       div_result,
  output logic                  we3,
  output logic [REG_ADDR_W-1:0] a3,
  output logic [XLEN-1:0]       wd3,
  output logic [XLEN-1:0]       pend_mask
);

  localparam int EW = $bits(wb_entry_t);

  wb_entry_t                       fifo_din;
  wb_entry_t                       fifo_head;
  logic                            fifo_push;
  logic                            fifo_pop;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [FIFO_DEPTH-1:0]           fifo_valid;
  logic [FIFO_DEPTH-1:0][EW-1:0]   fifo_entries;

  logic                  hold_valid;
  logic [REG_ADDR_W-1:0] hold_rd;
  logic [XLEN-1:0]       hold_data;
  logic                  hold_clr;
  logic                  div_load;
  grant_e                last_grant;
  grant_e                grant;

  // Entries that write nothing are accepted but never take a FIFO slot.
  assign in_ready  = !fifo_full;
  assign div_ready = !hold_valid;
  assign fifo_push = in_valid && in_ready && in_regwrite && (in_rd != '0);
  assign div_load  = div_valid && div_ready && (div_rd != '0);
  assign fifo_din  = '{rd: in_rd,
                       data: select_result(in_resultsrc, in_alu_result,
                                           in_read_data, in_pc_plus4)};

  wb_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W    (EW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .din        (fifo_din),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .entry_valid(fifo_valid),
    .entries    (fifo_entries)
  );

  // On contention the lane that did not win last time takes the port.
  always_comb begin
    grant = GRANT_PIPE;
    we3   = 1'b0;
    a3    = '0;
    wd3   = '0;
    if (!fifo_empty && hold_valid) begin
      grant = (last_grant == GRANT_DIV) ? GRANT_PIPE : GRANT_DIV;
    end else if (hold_valid) begin
      grant = GRANT_DIV;
    end
    if (!fifo_empty || hold_valid) begin
      we3 = 1'b1;
      if (grant == GRANT_PIPE) begin
        a3  = fifo_head.rd;
        wd3 = fifo_head.data;
      end else begin
        a3  = hold_rd;
        wd3 = hold_data;
      end
    end
  end

  assign fifo_pop = we3 && (grant == GRANT_PIPE);
  assign hold_clr = we3 && (grant == GRANT_DIV);

  // A full holder is never reloaded, so clear and load never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_rd    <= '0;
      hold_data  <= '0;
      last_grant <= GRANT_DIV;
    end else begin
      if (hold_clr) begin
        hold_valid <= 1'b0;
      end
      if (div_load) begin
        hold_valid <= 1'b1;
        hold_rd    <= div_rd;
        hold_data  <= div_result;
      end
      if (we3) begin
        last_grant <= grant;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_valid[i]) begin
        pend_mask = pend_mask | (XLEN'(1) << fifo_entries[i][XLEN +: REG_ADDR_W]);
      end
    end
    if (hold_valid) begin
      pend_mask = pend_mask | (XLEN'(1) << hold_rd);
    end
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_regwrite;
  logic [4:0]  in_rd;
  logic [1:0]  in_resultsrc;
  logic [31:0] in_alu_result;
  logic [31:0] in_read_data;
  logic [31:0] in_pc_plus4;
  logic        div_valid;
  logic        div_ready;
  logic [4:0]  div_rd;
  logic [31:0] div_result;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] pend_mask;

  int n_cmp = 0;
  int n_bad = 0;

  writeback_stage #(.FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_regwrite  (in_regwrite),
    .in_rd        (in_rd),
    .in_resultsrc (in_resultsrc),
    .in_alu_result(in_alu_result),
    .in_read_data (in_read_data),
    .in_pc_plus4  (in_pc_plus4),
    .div_valid    (div_valid),
    .div_ready    (div_ready),
    .div_rd       (div_rd),
    .div_result   (div_result),
    .we3          (we3),
    .a3           (a3),
    .wd3          (wd3),
    .pend_mask    (pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: pending pipeline writes in order, one divider slot.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ment_t;

  ment_t       m_q[$];
  logic        m_hv;
  logic [4:0]  m_hrd;
  logic [31:0] m_hd;
  logic        m_last_div;

  task automatic model_reset();
    m_q.delete();
    m_hv       = 1'b0;
    m_hrd      = '0;
    m_hd       = '0;
    m_last_div = 1'b1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check against the model, advance the
  // model through the coming rising edge.
  task automatic apply_stimulus(
    input logic iv, input logic rw, input logic [4:0] rd, input logic [1:0] rs,
    input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
    input logic dv, input logic [4:0] drd, input logic [31:0] dres,
    output logic o_we, output logic [4:0] o_a3, output logic [31:0] o_wd,
    output logic [31:0] o_mask);
    logic        pc, dc, gp, e_we, e_ir, e_dr;
    logic [4:0]  e_a3;
    logic [31:0] e_wd, e_mask, sel;
    @(negedge clk);
    in_valid = iv; in_regwrite = rw; in_rd = rd; in_resultsrc = rs;
    in_alu_result = alu; in_read_data = mem; in_pc_plus4 = pc4;
    div_valid = dv; div_rd = drd; div_result = dres;
    #1;
    pc     = (m_q.size() > 0);
    dc     = m_hv;
    gp     = (pc && dc) ? m_last_div : pc;
    e_we   = pc || dc;
    e_a3   = 5'd0;
    e_wd   = 32'd0;
    if (e_we) begin
      e_a3 = gp ? m_q[0].rd   : m_hrd;
      e_wd = gp ? m_q[0].data : m_hd;
    end
    e_mask = 32'd0;
    foreach (m_q[i]) e_mask[m_q[i].rd] = 1'b1;
    if (m_hv) e_mask[m_hrd] = 1'b1;
    e_mask[0] = 1'b0;
    e_ir = (m_q.size() < 2);
    e_dr = !m_hv;
    check_output("we3", {31'd0, we3}, {31'd0, e_we});
    check_output("a3", {27'd0, a3}, {27'd0, e_a3});
    check_output("wd3", wd3, e_wd);
    check_output("pend_mask", pend_mask, e_mask);
    check_output("in_ready", {31'd0, in_ready}, {31'd0, e_ir});
    check_output("div_ready", {31'd0, div_ready}, {31'd0, e_dr});
    o_we = we3; o_a3 = a3; o_wd = wd3; o_mask = pend_mask;
    if (e_we) begin
      if (gp) void'(m_q.pop_front());
      else m_hv = 1'b0;
      m_last_div = !gp;
    end
    if (iv && e_ir && rw && rd != 5'd0) begin
      sel = (rs == 2'b01) ? mem : (rs == 2'b10) ? pc4 : alu;
      m_q.push_back('{rd: rd, data: sel});
    end
    if (dv && e_dr && drd != 5'd0) begin
      m_hv = 1'b1; m_hrd = drd; m_hd = dres;
    end
    @(posedge clk);
  endtask

  task automatic idle(output logic o_we, output logic [4:0] o_a3,
                      output logic [31:0] o_wd, output logic [31:0] o_mask);
    apply_stimulus(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 32'd0,
                   1'b0, 5'd0, 32'd0, o_we, o_a3, o_wd, o_mask);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0; div_valid = 1'b0; in_regwrite = 1'b0;
    @(posedge clk);
    #1;
    check_output("rst_we3", {31'd0, we3}, 32'd0);
    check_output("rst_pend_mask", pend_mask, 32'd0);
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("rst_div_ready", {31'd0, div_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic [31:0] e_mask;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic        o_we;
    logic [4:0]  o_a3;
    logic [31:0] o_wd, o_mask;
    logic [4:0]  exp_seq[4];

    vecs[0] = '{1'b1, 5'd5,  2'b01, 32'h11111111, 32'hDEADBEEF, 32'h00000104,
                1'b1, 5'd5,  32'hDEADBEEF, 32'h00000020};
    vecs[1] = '{1'b1, 5'd1,  2'b00, 32'hA5A5A5A5, 32'h22222222, 32'h00000108,
                1'b1, 5'd1,  32'hA5A5A5A5, 32'h00000002};
    vecs[2] = '{1'b1, 5'd31, 2'b10, 32'h33333333, 32'h44444444, 32'h00001004,
                1'b1, 5'd31, 32'h00001004, 32'h80000000};
    vecs[3] = '{1'b1, 5'd12, 2'b11, 32'h12345678, 32'h55555555, 32'h00000200,
                1'b1, 5'd12, 32'h12345678, 32'h00001000};
    vecs[4] = '{1'b0, 5'd9,  2'b00, 32'h66666666, 32'h77777777, 32'h00000300,
                1'b0, 5'd0,  32'h00000000, 32'h00000000};
    vecs[5] = '{1'b1, 5'd0,  2'b01, 32'h88888888, 32'h99999999, 32'h00000400,
                1'b0, 5'd0,  32'h00000000, 32'h00000000};

    rst_n = 1'b0;
    in_valid = 1'b0; in_regwrite = 1'b0; in_rd = '0; in_resultsrc = '0;
    in_alu_result = '0; in_read_data = '0; in_pc_plus4 = '0;
    div_valid = 1'b0; div_rd = '0; div_result = '0;
    model_reset();
    do_reset();

    // Single pipeline writes: visible the cycle after acceptance, gone after.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, vecs[i].rw, vecs[i].rd, vecs[i].rs, vecs[i].alu,
                     vecs[i].mem, vecs[i].pc4, 1'b0, 5'd0, 32'd0,
                     o_we, o_a3, o_wd, o_mask);
      idle(o_we, o_a3, o_wd, o_mask);
      check_output($sformatf("vec%0d_we3", i), {31'd0, o_we}, {31'd0, vecs[i].e_we});
      check_output($sformatf("vec%0d_a3", i), {27'd0, o_a3}, {27'd0, vecs[i].e_a3});
      check_output($sformatf("vec%0d_wd3", i), o_wd, vecs[i].e_wd);
      check_output($sformatf("vec%0d_mask", i), o_mask, vecs[i].e_mask);
      idle(o_we, o_a3, o_wd, o_mask);
      check_output($sformatf("vec%0d_mask_after", i), o_mask, 32'd0);
    end

    // Divider result to x0 is swallowed.
    apply_stimulus(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 32'd0,
                   1'b1, 5'd0, 32'hCAFEF00D, o_we, o_a3, o_wd, o_mask);
    idle(o_we, o_a3, o_wd, o_mask);
    check_output("div_x0_we3", {31'd0, o_we}, 32'd0);
    check_output("div_x0_mask", o_mask, 32'd0);

    // Contention from reset: expected grant order x3, x7, x4, x6.
    do_reset();
    exp_seq[0] = 5'd3; exp_seq[1] = 5'd7; exp_seq[2] = 5'd4; exp_seq[3] = 5'd6;
    apply_stimulus(1'b1, 1'b1, 5'd3, 2'b00, 32'h300, 32'd0, 32'd0,
                   1'b1, 5'd7, 32'h700, o_we, o_a3, o_wd, o_mask);
    apply_stimulus(1'b1, 1'b1, 5'd4, 2'b00, 32'h400, 32'd0, 32'd0,
                   1'b0, 5'd0, 32'd0, o_we, o_a3, o_wd, o_mask);
    check_output("cont_grant0", {27'd0, o_a3}, {27'd0, exp_seq[0]});
    apply_stimulus(1'b1, 1'b1, 5'd6, 2'b00, 32'h600, 32'd0, 32'd0,
                   1'b0, 5'd0, 32'd0, o_we, o_a3, o_wd, o_mask);
    check_output("cont_grant1", {27'd0, o_a3}, {27'd0, exp_seq[1]});
    idle(o_we, o_a3, o_wd, o_mask);
    check_output("cont_grant2", {27'd0, o_a3}, {27'd0, exp_seq[2]});
    idle(o_we, o_a3, o_wd, o_mask);
    check_output("cont_grant3", {27'd0, o_a3}, {27'd0, exp_seq[3]});
    idle(o_we, o_a3, o_wd, o_mask);

    // Backpressure: pipeline held valid while the divider competes.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 1'b1, 5'(i + 1), 2'b00, $urandom, 32'd0, 32'd0,
                     (i % 3) == 0, 5'(20 + i), $urandom, o_we, o_a3, o_wd, o_mask);
    end
    for (int i = 0; i < 4; i++) idle(o_we, o_a3, o_wd, o_mask);

    // Fill to a full FIFO, then reset asynchronously mid-cycle.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b1, 5'(2 + i), 2'b01, 32'd0, $urandom, 32'd0,
                     1'b1, 5'(10 + i), $urandom, o_we, o_a3, o_wd, o_mask);
    end
    @(negedge clk);
    in_valid = 1'b0; div_valid = 1'b0;
    #1;
    check_output("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("pre_rst_we3", {31'd0, we3}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("async_rst_we3", {31'd0, we3}, 32'd0);
    check_output("async_rst_mask", pend_mask, 32'd0);
    @(posedge clk);
    #1;
    check_output("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("mid_rst_div_ready", {31'd0, div_ready}, 32'd1);
    check_output("mid_rst_we3", {31'd0, we3}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      apply_stimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) != 0),
                     5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                     $urandom, $urandom, $urandom,
                     ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
                     $urandom, o_we, o_a3, o_wd, o_mask);
    end
    for (int i = 0; i < 4; i++) idle(o_we, o_a3, o_wd, o_mask);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
